// File: rtl/seq_arith_unit_if.sv
// Operand/result bus between the operand registers, the arithmetic unit
// and the display mux. The master drives the request, the slave (the unit)
// drives the registered result and the status bits.
interface seq_arith_unit_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [2*WIDTH-1:0]   result;
  logic                 flag;
  logic                 busy;
  logic                 done;

  modport master (
    output start, op, x, y,
    input  result, flag, busy, done
  );

  modport slave (
    input  start, op, x, y,
    output result, flag, busy, done
  );
endinterface

// File: rtl/seq_arith_unit.sv
// Multi-cycle arithmetic unit: add, subtract, shift-add multiply and
// restoring divide on WIDTH-bit unsigned operands, with start/busy/done.
// Optional build macro SEQ_ARITH_SATURATE_EN makes add clamp to all ones on
// carry and sub clamp to zero on borrow; the flag is unchanged either way.
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_arith_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_flag;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH:0]       w_addSum;
  logic [WIDTH:0]       w_subDiff;
  logic [WIDTH:0]       w_mulSum;
  logic [2*WIDTH-1:0]   w_mulNext;
  logic [WIDTH:0]       w_divShift;
  logic [WIDTH:0]       w_divDiff;
  logic [WIDTH-1:0]     w_divRem;
  logic [2*WIDTH-1:0]   w_divNext;
  logic [WIDTH-1:0]     w_addOut;
  logic [WIDTH-1:0]     w_subOut;

  // Datapath for one iteration of every operation, computed from the
  // latched operands and the shared accumulator. For mul the accumulator
  // holds {partial product, remaining multiplier bits}; for div it holds
  // {partial remainder, remaining dividend bits / quotient bits so far}.
  always_comb begin
    w_addSum   = {1'b0, r_x} + {1'b0, r_y};
    w_subDiff  = {1'b0, r_x} - {1'b0, r_y};

    w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_x} : '0);
    w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

    w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_divDiff  = w_divShift - {1'b0, r_y};
    w_divRem   = w_divDiff[WIDTH] ? w_divShift[WIDTH-1:0] : w_divDiff[WIDTH-1:0];
    w_divNext  = {w_divRem, r_acc[WIDTH-2:0], ~w_divDiff[WIDTH]};

`ifdef SEQ_ARITH_SATURATE_EN
    w_addOut   = w_addSum[WIDTH]  ? {WIDTH{1'b1}} : w_addSum[WIDTH-1:0];
    w_subOut   = w_subDiff[WIDTH] ? {WIDTH{1'b0}} : w_subDiff[WIDTH-1:0];
`else
    w_addOut   = w_addSum[WIDTH-1:0];
    w_subOut   = w_subDiff[WIDTH-1:0];
`endif
  end

  // Control FSM: latches a request in IDLE, iterates in CALC and loads the
  // registered result, flag and one-cycle done pulse on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_acc   <= (bus.op == OP_DIV) ? {{WIDTH{1'b0}}, bus.x} : {{WIDTH{1'b0}}, bus.y};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          case (r_op)
            OP_ADD: begin
              r_result <= {{WIDTH{1'b0}}, w_addOut};
              r_flag   <= w_addSum[WIDTH];
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
            OP_SUB: begin
              r_result <= {{WIDTH{1'b0}}, w_subOut};
              r_flag   <= w_subDiff[WIDTH];
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
            OP_MUL: begin
              r_acc <= w_mulNext;
              if (r_count == LAST_ITER) begin
                r_result <= w_mulNext;
                r_flag   <= |w_mulNext[2*WIDTH-1:WIDTH];
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= IDLE;
              end else begin
                r_count <= r_count + CW'(1);
              end
            end
            default: begin
              if (r_y == '0) begin
                r_result <= {r_x, {WIDTH{1'b1}}};
                r_flag   <= 1'b1;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= IDLE;
              end else begin
                r_acc <= w_divNext;
                if (r_count == LAST_ITER) begin
                  r_result <= w_divNext;
                  r_flag   <= 1'b0;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
                end else begin
                  r_count <= r_count + CW'(1);
                end
              end
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.flag   = r_flag;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed testbench for seq_arith_unit: one WIDTH=4 and one WIDTH=8
// instance sharing clock and reset, with hand-computed expected values.
module tb_seq_arith_unit;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  seq_arith_unit_if #(.WIDTH(4)) bus4 ();
  seq_arith_unit_if #(.WIDTH(8)) bus8 ();

  seq_arith_unit #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  seq_arith_unit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request on the falling edge, holds start through the
  // accepting rising edge, then drops it just after that edge.
  task automatic applyStimulus(input bit wide, input logic [1:0] op,
                               input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    if (wide) begin
      bus8.op = op; bus8.x = x; bus8.y = y; bus8.start = 1'b1;
    end else begin
      bus4.op = op; bus4.x = x[3:0]; bus4.y = y[3:0]; bus4.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until done is seen.
  task automatic waitDone(input bit wide, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (wide ? bus8.done : bus4.done) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Full operation: issue, wait for done, check latency, result and flag.
  task automatic runOp(input string tag, input bit wide, input logic [1:0] op,
                       input logic [7:0] x, input logic [7:0] y,
                       input int expLat, input logic [15:0] expResult,
                       input logic expFlag);
    int lat;
    applyStimulus(wide, op, x, y);
    waitDone(wide, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_result"}, wide ? 32'(bus8.result) : 32'(bus4.result), 32'(expResult));
    checkOutput({tag, "_flag"}, wide ? 32'(bus8.flag) : 32'(bus4.flag), 32'(expFlag));
  endtask

  // Main directed sequence.
  initial begin
    int pulses;
    logic [15:0] expAddSat;
    logic [15:0] expSubSat;

`ifdef SEQ_ARITH_SATURATE_EN
    expAddSat = 16'h0F;
    expSubSat = 16'h00;
`else
    expAddSat = 16'h01;
    expSubSat = 16'h0E;
`endif

    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.op = OP_ADD; bus4.x = '0; bus4.y = '0;
    bus8.start = 1'b0; bus8.op = OP_ADD; bus8.x = '0; bus8.y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_result", 32'(bus4.result), 32'h0);
    checkOutput("reset_flag", 32'(bus4.flag), 32'h0);
    checkOutput("reset_busy", 32'(bus4.busy), 32'h0);
    checkOutput("reset_done", 32'(bus4.done), 32'h0);
    checkOutput("reset_result8", 32'(bus8.result), 32'h0);

    runOp("add_9_8", 1'b0, OP_ADD, 8'd9, 8'd8, 1, expAddSat, 1'b1);
    @(posedge clk); #1;
    checkOutput("add_done_pulse", 32'(bus4.done), 32'h0);
    checkOutput("add_result_hold", 32'(bus4.result), 32'(expAddSat));

    runOp("sub_3_5", 1'b0, OP_SUB, 8'd3, 8'd5, 1, expSubSat, 1'b1);
    runOp("sub_7_2", 1'b0, OP_SUB, 8'd7, 8'd2, 1, 16'h05, 1'b0);

    // Multiply with a second start and changed operands raised mid-operation.
    applyStimulus(1'b0, OP_MUL, 8'd15, 8'd15);
    checkOutput("mul_busy_c0", 32'(bus4.busy), 32'h1);
    bus4.start = 1'b1; bus4.op = OP_ADD; bus4.x = 4'd1; bus4.y = 4'd1;
    @(posedge clk); #1;
    checkOutput("mul_busy_c1", 32'(bus4.busy), 32'h1);
    checkOutput("mul_done_c1", 32'(bus4.done), 32'h0);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    checkOutput("mul_busy_c2", 32'(bus4.busy), 32'h1);
    @(posedge clk); #1;
    checkOutput("mul_done_c3", 32'(bus4.done), 32'h0);
    @(posedge clk); #1;
    checkOutput("mul_done_c4", 32'(bus4.done), 32'h1);
    checkOutput("mul_busy_c4", 32'(bus4.busy), 32'h0);
    checkOutput("mul_15_15_result", 32'(bus4.result), 32'hE1);
    checkOutput("mul_15_15_flag", 32'(bus4.flag), 32'h1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus4.done) pulses++;
    end
    checkOutput("mul_extra_done", 32'(pulses), 32'h0);
    checkOutput("mul_result_hold", 32'(bus4.result), 32'hE1);

    runOp("div_13_4", 1'b0, OP_DIV, 8'd13, 8'd4, 4, 16'h13, 1'b0);
    runOp("div_7_0", 1'b0, OP_DIV, 8'd7, 8'd0, 1, 16'h7F, 1'b1);

    // WIDTH=8 multiply followed by an add started in the done cycle.
    runOp("mul8_255_255", 1'b1, OP_MUL, 8'd255, 8'd255, 8, 16'hFE01, 1'b1);
    runOp("add8_b2b", 1'b1, OP_ADD, 8'd1, 8'd1, 1, 16'h0002, 1'b0);

    // Reset asserted during the second cycle of a WIDTH=4 multiply.
    applyStimulus(1'b0, OP_MUL, 8'd15, 8'd15);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_busy", 32'(bus4.busy), 32'h0);
    checkOutput("rst_mid_done", 32'(bus4.done), 32'h0);
    checkOutput("rst_mid_result", 32'(bus4.result), 32'h0);
    checkOutput("rst_mid_flag", 32'(bus4.flag), 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.done) pulses++;
    end
    checkOutput("rst_mid_no_done", 32'(pulses), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, multi-cycle arithmetic unit: add, subtract, full-width multiply, divide with remainder.
- Handles WIDTH-bit operands with a start/busy/done handshake.
- Multiply uses an iterative shift-add datapath; divide uses an iterative restoring datapath. Both complete in WIDTH cycles.
- Sits between the operand switches/registers and the display mux. Drives a registered result plus one status flag for the LED.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  operation: 0=add, 1=sub, 2=mul, 3=div.
- x  input  WIDTH  operand A (dividend for div).
- y  input  WIDTH  operand B (divisor for div).
- result  output  2*WIDTH  registered result; held until the next completion.
- flag  output  1  status bit for the completed op (carry/borrow/overflow/div-by-zero).
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse on completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; result=0, flag=0, busy=0, done=0.
  - Internal accumulators and counter are cleared.
  - Reset mid-operation aborts with no partial result.
- States:
  - IDLE: busy=0. Accept when start=1. Latch x, y, op. Go to CALC; busy=1 from the next cycle.
  - CALC: one iteration per clock. Iteration count N: add/sub N=1; mul N=WIDTH; div N=WIDTH; div with y=0 N=1.
  - On the edge completing iteration N: load result and flag, pulse done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is visible N cycles after the accepting edge.
- Back-to-back: start high in the done cycle is accepted (busy=0 then).
- start while busy=1 is ignored. Operand changes during CALC are ignored (latched copies are used).
- add:
  - result[WIDTH-1:0] = (x+y) mod 2^WIDTH; upper bits 0.
  - flag = carry out.
- sub:
  - result[WIDTH-1:0] = (x-y) mod 2^WIDTH; upper bits 0.
  - flag = borrow (x<y).
- mul:
  - Unsigned, result = x*y, full 2*WIDTH bits.
  - flag = 1 if result[2*WIDTH-1:WIDTH] != 0.
  - Shift-add: each iteration examines one multiplier LSB, conditionally adds the multiplicand into the upper half, then shifts right.
- div:
  - Unsigned restoring division.
  - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
  - flag = 0 for a normal divide.
  - One quotient bit per iteration, MSB first.
- div by zero (y=0):
  - Completes in 1 cycle.
  - quotient = all ones; remainder = x; flag = 1.
- Between completions, result and flag hold their last values; done=0.

Optional Feature:
- Macro SEQ_ARITH_SATURATE_EN.
- Defined:
  - add with carry: result[WIDTH-1:0] = all ones.
  - sub with borrow: result[WIDTH-1:0] = 0.
  - flag is still set as in the non-saturating case.
  - mul and div are unaffected.
- Undefined: add/sub wrap modulo 2^WIDTH as specified above.

Test Plan:
- WIDTH=4, add x=9 y=8 -> done 1 cycle after accept, result=0x01, flag=1; with SEQ_ARITH_SATURATE_EN result=0x0F.
- WIDTH=4, sub x=3 y=5 -> result=0x0E, flag=1; saturating build result=0x00, flag=1. Also sub x=7 y=2 -> result=0x05, flag=0.
- WIDTH=4, mul x=15 y=15 -> busy for 4 cycles, done 4 cycles after accept, result=0xE1, flag=1. A second start raised mid-operation is ignored and produces no extra done.
- WIDTH=4, div x=13 y=4 -> done after 4 cycles, result=0x13 (rem 1, quot 3), flag=0. div x=7 y=0 -> done after 1 cycle, result=0x7F, flag=1.
- WIDTH=8, mul x=255 y=255 -> done after 8 cycles, result=0xFE01, flag=1. Then immediate back-to-back add x=1 y=1 started in the done cycle -> result=0x0002, flag=0.
- Reset check: assert rst for 1 cycle during cycle 2 of a WIDTH=4 mul -> next cycle busy=0, done=0, result=0, flag=0, and no done pulse follows.
